// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM arbiter.
package rom_arb_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 8;

  localparam logic PORT_VIDEO = 1'b0;
  localparam logic PORT_CPU   = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;
endpackage

// File: rtl/rom_arbiter_if.sv
// Requester and ROM-side signals of the arbiter.
// The master side drives the requests and the ROM read data.
interface rom_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] data0, data1;
  logic              valid0, valid1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (
    output req0, addr0, req1, addr1, rom_data,
    input  ack0, data0, valid0, ack1, data1, valid1, rom_addr
  );
  modport slave (
    input  req0, addr0, req1, addr1, rom_data,
    output ack0, data0, valid0, ack1, data1, valid1, rom_addr
  );
endinterface

// File: rtl/rom_arb_tag_pipe.sv
// Two-stage tag shift register that follows each fetch through the ROM.
// Stage A holds the tag for the address in flight; stage B lines up with rom_data.
module rom_arb_tag_pipe
  import rom_arb_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t [1:0] stg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stg <= '0;
    else          stg <= {stg[0], tag_in};
  end

  assign tag_out = stg[1];
endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter for a 1-cycle registered ROM; port 0 (video) has priority,
// port 1 (CPU) is forced through after MAX_WAIT denied cycles.
// Define ROM_ARB_HOLD_EN to give each port its own data register that holds between pulses.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
)(
  input logic          clock,
  input logic          reset_n,
  rom_arbiter_if.slave bus
);
  logic [7:0]        starve;
  logic              force1, ack0, ack1;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              valid0_q, valid1_q;
  tag_t              tag_in, tag_b;

  // Acks are qualified by reset_n so nothing is granted while reset is held.
  assign force1 = (starve == 8'(MAX_WAIT));
  assign ack1   = reset_n & bus.req1 & (~bus.req0 | force1);
  assign ack0   = reset_n & bus.req0 & ~ack1;

  assign tag_in.valid = ack0 | ack1;
  assign tag_in.port  = ack1 ? PORT_CPU : PORT_VIDEO;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      starve     <= '0;
    end else begin
      if (ack1)      rom_addr_q <= bus.addr1;
      else if (ack0) rom_addr_q <= bus.addr0;
      if (!bus.req1 || ack1) starve <= '0;
      else if (!force1)      starve <= starve + 8'd1;
    end
  end

  rom_arb_tag_pipe u_tags (
    .clock   (clock),
    .reset_n (reset_n),
    .tag_in  (tag_in),
    .tag_out (tag_b)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      valid0_q <= tag_b.valid & (tag_b.port == PORT_VIDEO);
      valid1_q <= tag_b.valid & (tag_b.port == PORT_CPU);
    end
  end

`ifdef ROM_ARB_HOLD_EN
  logic [DATA_W-1:0] data0_q, data1_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data0_q <= '0;
      data1_q <= '0;
    end else if (tag_b.valid) begin
      if (tag_b.port == PORT_VIDEO) data0_q <= bus.rom_data;
      else                          data1_q <= bus.rom_data;
    end
  end

  assign bus.data0 = data0_q;
  assign bus.data1 = data1_q;
`else
  // One shared capture register; only the owner's valid pulse qualifies it.
  logic [DATA_W-1:0] cap_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         cap_q <= '0;
    else if (tag_b.valid) cap_q <= bus.rom_data;
  end

  assign bus.data0 = cap_q;
  assign bus.data1 = cap_q;
`endif

  assign bus.ack0     = ack0;
  assign bus.ack1     = ack1;
  assign bus.valid0   = valid0_q;
  assign bus.valid1   = valid1_q;
  assign bus.rom_addr = rom_addr_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: cycle tables for arbitration/streaming plus
// hand sequences for reset, mid-operation reset and the data hold option.
module tb_rom_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  rom_arbiter_if #(.ADDR_W(13), .DATA_W(8)) bus ();

  rom_arbiter #(.ADDR_W(13), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] rom [0:8191];

  always @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

  function automatic logic [7:0] img(input logic [12:0] a);
    return (a[7:0] + 8'h3B) ^ {3'b000, a[12:8]};
  endfunction

  typedef struct {
    logic        r0;
    logic [12:0] a0;
    logic        r1;
    logic [12:0] a1;
    logic        ea0, ea1, ev0, ev1;
    logic [7:0]  ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r0, input logic [12:0] a0, input logic r1,
                     input logic [12:0] a1, input logic ea0, input logic ea1,
                     input logic ev0, input logic ev1, input logic [7:0] ed);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
    v.ea0 = ea0; v.ea1 = ea1; v.ev0 = ev0; v.ev1 = ev1; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic [12:0] a0, input logic r1, input logic [12:0] a1);
    bus.req0 = r0; bus.addr0 = a0; bus.req1 = r1; bus.addr1 = a1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = img(13'(i));
    rom[13'h1000] = 8'hA9;
    rom[13'h0020] = 8'h55;
    rom[13'h1020] = 8'hAA;
    bus.rom_data = 8'h00;

    // Contention: both held, MAX_WAIT=4 -> 4 x ack0 then 1 x ack1; data 3 rows after issue.
    add(1,13'h100,1,13'h1000, 1,0, 0,0, 8'h00);
    add(1,13'h101,1,13'h1000, 1,0, 0,0, 8'h00);
    add(1,13'h102,1,13'h1000, 1,0, 0,0, 8'h00);
    add(1,13'h103,1,13'h1000, 1,0, 1,0, rom[13'h100]);
    add(1,13'h104,1,13'h1000, 0,1, 1,0, rom[13'h101]);
    add(1,13'h104,1,13'h1001, 1,0, 1,0, rom[13'h102]);
    add(1,13'h105,1,13'h1001, 1,0, 1,0, rom[13'h103]);
    add(1,13'h106,1,13'h1001, 1,0, 0,1, 8'hA9);
    add(1,13'h107,1,13'h1001, 1,0, 1,0, rom[13'h104]);
    add(1,13'h108,1,13'h1001, 0,1, 1,0, rom[13'h105]);
    add(0,13'h000,0,13'h0000, 0,0, 1,0, rom[13'h106]);
    add(0,13'h000,0,13'h0000, 0,0, 1,0, rom[13'h107]);
    add(0,13'h000,0,13'h0000, 0,0, 0,1, rom[13'h1001]);
    add(0,13'h000,0,13'h0000, 0,0, 0,0, 8'h00);
    // Port 0 stream 0..7 with no bubbles.
    for (int i = 0; i < 12; i++)
      add(i < 8, 13'(i < 8 ? i : 0), 0, 13'h0, i < 8, 0,
          i >= 3 && i <= 10, 0, (i >= 3 && i <= 10) ? rom[13'(i-3)] : 8'h00);
    // Port 1 drops its request before ack: no fetch, starve clears.
    add(1,13'h200,1,13'h1500, 1,0, 0,0, 8'h00);
    add(1,13'h201,1,13'h1500, 1,0, 0,0, 8'h00);
    add(1,13'h202,0,13'h0000, 1,0, 0,0, 8'h00);
    add(1,13'h203,1,13'h1501, 1,0, 1,0, rom[13'h200]);
    add(1,13'h204,1,13'h1501, 1,0, 1,0, rom[13'h201]);
    add(1,13'h205,1,13'h1501, 1,0, 1,0, rom[13'h202]);
    add(1,13'h206,1,13'h1501, 1,0, 1,0, rom[13'h203]);
    add(1,13'h207,1,13'h1501, 0,1, 1,0, rom[13'h204]);
    add(0,13'h000,0,13'h0000, 0,0, 1,0, rom[13'h205]);
    add(0,13'h000,0,13'h0000, 0,0, 1,0, rom[13'h206]);
    add(0,13'h000,0,13'h0000, 0,0, 0,1, rom[13'h1501]);
    add(0,13'h000,0,13'h0000, 0,0, 0,0, 8'h00);

    // Reset state, with requests present during reset.
    drive(1, 13'h0011, 1, 13'h1011);
    #2;
    chk("rst_ack0", bus.ack0, 0);
    chk("rst_ack1", bus.ack1, 0);
    chk("rst_valid0", bus.valid0, 0);
    chk("rst_valid1", bus.valid1, 0);
    chk("rst_data0", bus.data0, 0);
    chk("rst_data1", bus.data1, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Single port 1 fetch of 0x1000.
    @(negedge clock); drive(0, 0, 1, 13'h1000);
    #1; chk("single_ack1", bus.ack1, 1); chk("single_ack0", bus.ack0, 0);
    @(negedge clock); drive(0, 0, 0, 0);
    chk("single_rom_addr", bus.rom_addr, 13'h1000);
    chk("single_v1_e0", bus.valid1, 0);
    @(negedge clock); chk("single_v1_e1", bus.valid1, 0);
    @(negedge clock);
    chk("single_v1", bus.valid1, 1);
    chk("single_data1", bus.data1, 8'hA9);
    chk("single_v0", bus.valid0, 0);
    @(negedge clock); chk("single_v1_end", bus.valid1, 0);

    // Table-driven rows: registered outputs checked before driving, acks after.
    foreach (vecs[i]) begin
      @(negedge clock);
      chk($sformatf("row%0d_valid0", i), bus.valid0, vecs[i].ev0);
      chk($sformatf("row%0d_valid1", i), bus.valid1, vecs[i].ev1);
      if (vecs[i].ev0) chk($sformatf("row%0d_data0", i), bus.data0, vecs[i].ed);
      if (vecs[i].ev1) chk($sformatf("row%0d_data1", i), bus.data1, vecs[i].ed);
      drive(vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1);
      #1;
      chk($sformatf("row%0d_ack0", i), bus.ack0, vecs[i].ea0);
      chk($sformatf("row%0d_ack1", i), bus.ack1, vecs[i].ea1);
    end

    // Reset one cycle after a port 1 transfer: the in-flight fetch is dropped.
    @(negedge clock); drive(0, 0, 1, 13'h1001);
    #1; chk("mid_ack1", bus.ack1, 1);
    @(negedge clock); drive(0, 0, 1, 13'h1000); reset_n = 1'b0;
    #1;
    chk("mid_rom_addr", bus.rom_addr, 0);
    chk("mid_data1", bus.data1, 0);
    chk("mid_ack1_in_rst", bus.ack1, 0);
    repeat (3) begin
      @(negedge clock);
      chk("mid_valid1_in_rst", bus.valid1, 0);
      chk("mid_valid0_in_rst", bus.valid0, 0);
    end
    reset_n = 1'b1; drive(0, 0, 0, 0);
    repeat (3) begin
      @(negedge clock);
      chk("mid_valid1_after", bus.valid1, 0);
    end
    drive(0, 0, 1, 13'h1000);
    #1; chk("mid_reack1", bus.ack1, 1);
    @(negedge clock); drive(0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    chk("mid_valid1_new", bus.valid1, 1);
    chk("mid_data1_new", bus.data1, 8'hA9);

    // 0x55 on port 0, then 0xAA on port 1: data0 afterwards depends on the hold option.
    @(negedge clock); drive(1, 13'h0020, 0, 0);
    #1; chk("hold_ack0", bus.ack0, 1);
    @(negedge clock); drive(0, 0, 1, 13'h1020);
    #1; chk("hold_ack1", bus.ack1, 1);
    @(negedge clock); drive(0, 0, 0, 0);
    @(negedge clock);
    chk("hold_valid0", bus.valid0, 1);
    chk("hold_data0", bus.data0, 8'h55);
    @(negedge clock);
    chk("hold_valid1", bus.valid1, 1);
    chk("hold_data1", bus.data1, 8'hAA);
`ifdef ROM_ARB_HOLD_EN
    chk("hold_data0_kept", bus.data0, 8'h55);
`else
    chk("hold_data0_shared", bus.data0, 8'hAA);
`endif
    @(negedge clock);
    chk("hold_valid1_end", bus.valid1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
